prog_sequencer: RTL
===================

Name: prog_sequencer

Overview:
- Control-side counterpart of the program counter: generates the PC's reset, enable, branch-enable, source-select and offset inputs.
- Runs the Start/Done program handshake with the testbench.
- Resolves bnzr/bnzl branches from decoded instruction flags and a programmable 8-entry branch-offset LUT.
- Sits between the instruction decoder, the register file read port and the PC.

Parameters:
- LUT_DEPTH, 8, number of branch-offset LUT entries (index width = clog2(LUT_DEPTH)).
- PC_W, 10, program counter and LUT entry width.
- REG_W, 8, register operand/offset width.
- CYC_W, 16, run-cycle counter width.

Ports:
- Clk  input  1  clock; all state changes on posedge.
- Reset  input  1  synchronous, active-high; clears all state.
- Start  input  1  request to run the program; sampled only in IDLE or DONE.
- Done  output  1  high while in DONE.
- IsBnzr  input  1  decoded bnzr (branch by register offset if operand nonzero).
- IsBnzl  input  1  decoded bnzl (branch by LUT offset if operand nonzero).
- IsHalt  input  1  decoded halt.
- LutIdx  input  clog2(LUT_DEPTH)  LUT index field of bnzl.
- TestVal  input  REG_W  register value tested for nonzero.
- OffReg  input  REG_W  register offset for bnzr.
- LutWe  input  1  LUT write enable; honoured in IDLE/DONE only.
- LutWaddr  input  clog2(LUT_DEPTH)  LUT write index.
- LutWdata  input  PC_W  LUT write data.
- PcReset  output  1  drives PC Reset.
- PcEn  output  1  drives PC En.
- BranchEn  output  1  drives PC BranchEn.
- Source  output  1  0 = LUT offset, 1 = register offset.
- LUTout  output  PC_W  LUT offset to PC.
- RegOut  output  REG_W  register offset to PC (equals OffReg).
- CycleCnt  output  CYC_W  RUN cycles of the last/current program.

Behaviour:
- States are IDLE, INIT, RUN and DONE. Reset puts the block in IDLE and clears the LUT to 0 and CycleCnt to 0.
- Transitions:
  - IDLE: Start=1 goes to INIT.
  - INIT always goes to RUN (exactly 1 cycle).
  - RUN: IsHalt=1 goes to DONE.
  - DONE: Start=1 goes to INIT; otherwise it holds. Done stays high until then.
- PcReset = (state==INIT). The PC therefore reads 0 on the first RUN cycle.
- PcEn = (state==RUN) && !IsHalt. It is combinational from the state register and decode, so the PC holds on the halt instruction.
- Branch resolution is combinational and active only in RUN with !IsHalt:
  - Priority is halt > bnzr > bnzl.
  - taken = (TestVal != 0).
  - bnzr taken: BranchEn=1, Source=1.
  - bnzl taken: BranchEn=1, Source=0, LUTout=LUT[LutIdx].
  - Not taken, or not a branch: BranchEn=0.
- Offsets are added by the PC modulo 2^PC_W.
  - A LUT entry is an unrestricted PC_W-bit value, so a backward branch is encoded as 2^PC_W - n.
  - The register offset is zero-extended, so it only branches forward.
- Outside RUN: BranchEn=0, PcEn=0, Source=0. LUTout is LUT[LutIdx] at all times (don't-care when BranchEn=0).
- CycleCnt:
  - Cleared in INIT.
  - Increments every RUN cycle, including the halt cycle.
  - Saturates at all-ones.
  - Holds in DONE and IDLE.
- LUT writes:
  - A write lands at posedge when LutWe=1 and the state is IDLE or DONE.
  - A write is ignored in INIT/RUN.
  - A read of the same index in the write cycle returns the old value.
- Start asserted in INIT or RUN is ignored. It is not queued.
- Reset mid-RUN: next cycle is IDLE with PcEn=0 and Done=0; LUT contents and CycleCnt are cleared.
- Illegal IsBnzr && IsBnzl is resolved by priority (bnzr wins). No error is flagged.

Decomposition:
- Package prog_seq_pkg contains:
  - state enum seq_state_t {IDLE, INIT, RUN, DONE}.
  - Constants LUT_DEPTH, PC_W, REG_W, CYC_W.
  - Typedef lut_idx_t.
- Sub-module branch_lut holds the register-array LUT with one write port and one async read port, and synchronous Reset clear.
- FSM, branch resolve and the counter stay in prog_sequencer.

Test Plan:
- Reset, then Start pulse in cycle 1: INIT in cycle 2 with PcReset=1; RUN in cycle 3 with PcEn=1, BranchEn=0; Done=0 throughout.
- Write LUT[3]=10'h3FC in IDLE, run, present IsBnzl, LutIdx=3, TestVal=8'h05: BranchEn=1, Source=0, LUTout=10'h3FC. Repeat with TestVal=0: BranchEn=0, PcEn=1.
- In RUN, IsBnzr, TestVal=1, OffReg=8'd7: BranchEn=1, Source=1, RegOut=7. Add IsBnzl simultaneously: Source still 1.
- Halt after 5 RUN cycles: PcEn=0 in the halt cycle, Done=1 next cycle, CycleCnt=5. A new Start gives INIT with CycleCnt=0.
- LutWe during RUN to index 2 (data 10'h123): LUT[2] unchanged, reads 0. Start ignored in RUN.
- Reset asserted mid-RUN: next cycle IDLE, PcEn=0, Done=0, CycleCnt=0, LUT reads 0.

Source files
------------

// File: rtl/prog_seq_pkg.sv
// Shared constants, LUT index type and sequencer state encoding for the
// program sequencer slice.
package prog_seq_pkg;

    localparam int LUT_DEPTH = 8;
    localparam int PC_W      = 10;
    localparam int REG_W     = 8;
    localparam int CYC_W     = 16;
    localparam int LUT_IDX_W = $clog2(LUT_DEPTH);

    typedef logic [LUT_IDX_W-1:0] lut_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/prog_sequencer_lut.sv
// Programmable branch-offset table: one write port, one asynchronous read port,
// and a synchronous clear of every entry on reset.
module branch_lut #(
    parameter int DEPTH = 8,
    parameter int W     = 10,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [W-1:0]     wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [W-1:0]     rdata_o
);

    logic [W-1:0] lut_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                lut_q[i] <= '0;
            end
        end else if (we_i) begin
            lut_q[waddr_i] <= wdata_i;
        end
    end

    // Read is combinational, so a same-cycle write is only visible next cycle.
    assign rdata_o = lut_q[raddr_i];

endmodule

// File: rtl/prog_sequencer.sv
// Control side of the program counter: Start/Done handshake, PC control strobes,
// bnzr/bnzl branch resolution and the run-cycle counter.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int LUT_DEPTH = prog_seq_pkg::LUT_DEPTH,
    parameter int PC_W      = prog_seq_pkg::PC_W,
    parameter int REG_W     = prog_seq_pkg::REG_W,
    parameter int CYC_W     = prog_seq_pkg::CYC_W
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Start,
    output logic                         Done,
    input  logic                         IsBnzr,
    input  logic                         IsBnzl,
    input  logic                         IsHalt,
    input  logic [$clog2(LUT_DEPTH)-1:0] LutIdx,
    input  logic [REG_W-1:0]             TestVal,
    input  logic [REG_W-1:0]             OffReg,
    input  logic                         LutWe,
    input  logic [$clog2(LUT_DEPTH)-1:0] LutWaddr,
    input  logic [PC_W-1:0]              LutWdata,
    output logic                         PcReset,
    output logic                         PcEn,
    output logic                         BranchEn,
    output logic                         Source,
    output logic [PC_W-1:0]              LUTout,
    output logic [REG_W-1:0]             RegOut,
    output logic [CYC_W-1:0]             CycleCnt
);

    seq_state_t       state_q, state_d;
    logic [CYC_W-1:0] cycleCnt_q, cycleCnt_d;
    logic             runActive;
    logic             taken;
    logic             bnzrTaken;
    logic             bnzlTaken;
    logic             lutWriteOk;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (Start)  state_d = INIT;
            INIT:                state_d = RUN;
            RUN:     if (IsHalt) state_d = DONE;
            DONE:    if (Start)  state_d = INIT;
            default:             state_d = IDLE;
        endcase
    end

    always_comb begin
        cycleCnt_d = cycleCnt_q;
        if (state_q == INIT) begin
            cycleCnt_d = '0;
        end else if (state_q == RUN && cycleCnt_q != {CYC_W{1'b1}}) begin
            cycleCnt_d = cycleCnt_q + CYC_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            cycleCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cycleCnt_q <= cycleCnt_d;
        end
    end

    // Halt outranks any branch decode, and bnzr outranks bnzl when both are set.
    assign runActive = (state_q == RUN) && !IsHalt;
    assign taken     = (TestVal != '0);
    assign bnzrTaken = runActive && IsBnzr && taken;
    assign bnzlTaken = runActive && !IsBnzr && IsBnzl && taken;

    assign PcReset  = (state_q == INIT);
    assign PcEn     = runActive;
    assign BranchEn = bnzrTaken || bnzlTaken;
    assign Source   = bnzrTaken;
    assign RegOut   = OffReg;
    assign Done     = (state_q == DONE);
    assign CycleCnt = cycleCnt_q;

    assign lutWriteOk = LutWe && (state_q == IDLE || state_q == DONE);

    branch_lut #(
        .DEPTH (LUT_DEPTH),
        .W     (PC_W)
    ) uBranchLut (
        .clk_i   (Clk),
        .reset_i (Reset),
        .we_i    (lutWriteOk),
        .waddr_i (LutWaddr),
        .wdata_i (LutWdata),
        .raddr_i (LutIdx),
        .rdata_o (LUTout)
    );

endmodule
